// File: rtl/ro_freq_meter.sv
// ---------------------------------------------------------------------------
// ro_freq_meter
//
// Measures the frequency of a free-running ring oscillator. It enables the
// oscillator, waits a fixed settle time, then counts rising edges of the
// synchronised oscillator output over a window of win_len clk cycles and
// reports the result with a one-cycle done pulse.
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst_n     synchronous reset, active low
//   start     measurement request, only honoured in IDLE
//   win_len   window length in clk cycles, captured on accepted start
//   ro_q      oscillator output, asynchronous to clk
//   ro_en     oscillator enable (registered)
//   busy      high whenever the meter is not idle
//   done      one-cycle pulse, count/overflow valid
//   count     rising edges seen in the last window (saturating)
//   overflow  edge counter saturated during the last window
// ---------------------------------------------------------------------------
module ro_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SETTLE_CYC  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             ro_q,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DONE
    } state_t;

    state_t               state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                 prev_reg;
    logic                 rise;
    logic [WIN_W-1:0]     win_reg;
    logic [SET_W-1:0]     settle_reg;
    logic [CNT_W-1:0]     edge_reg;
    logic                 sat_reg;
    logic [CNT_W-1:0]     edge_next;
    logic                 sat_next;

    // Synchroniser and edge detector run in every state so that a level
    // already high when the window opens never looks like a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], ro_q};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

    // Saturating edge count including this cycle's sample; the final window
    // sample must land in count on the same edge that enters DONE.
    always_comb begin
        edge_next = edge_reg;
        sat_next  = sat_reg;
        if (rise) begin
            if (&edge_reg) begin
                sat_next = 1'b1;
            end else begin
                edge_next = edge_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            win_reg    <= '0;
            settle_reg <= '0;
            edge_reg   <= '0;
            sat_reg    <= 1'b0;
            ro_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ro_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        win_reg    <= win_len;
                        edge_reg   <= '0;
                        sat_reg    <= 1'b0;
                        settle_reg <= '0;
                        ro_en      <= 1'b1;
                        busy       <= 1'b1;
                        state_reg  <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (settle_reg == SET_W'(SETTLE_CYC - 1)) begin
                        if (win_reg != '0) begin
                            state_reg <= MEASURE;
                        end else begin
                            // Empty window: report straight away.
                            state_reg <= DONE;
                            ro_en     <= 1'b0;
                            done      <= 1'b1;
                            count     <= edge_reg;
                            overflow  <= sat_reg;
                        end
                    end else begin
                        settle_reg <= settle_reg + 1'b1;
                    end
                end

                MEASURE: begin
                    edge_reg <= edge_next;
                    sat_reg  <= sat_next;
                    win_reg  <= win_reg - 1'b1;
                    if (win_reg == WIN_W'(1)) begin
                        state_reg <= DONE;
                        ro_en     <= 1'b0;
                        done      <= 1'b1;
                        count     <= edge_next;
                        overflow  <= sat_next;
                    end
                end

                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
